// File: rtl/data_bus_ctrl.sv
// Data bus controller: routes core loads/stores to RAM (zero stall) or to a
// UART window (core frozen until the UART answers or a timeout expires),
// and gives a boot loader priority write access to RAM while idle.
// Ports: clk/rst (sync, active-high); core c_* request/response and c_clkEn
// freeze; loader l_req/l_addr/l_wdata/l_gnt; RAM ram_* strobe interface with
// one-cycle read latency; UART uart_* valid/ready interface.
module data_bus_ctrl #(
  parameter logic [31:0] UART_BASE = 32'h1000_0000,
  parameter logic [31:0] UART_MASK = 32'hF000_0000,
  parameter int unsigned TO_CYC    = 255
) (
  input  logic        clk,
  input  logic        rst,
  // core side
  input  logic        c_rdEn,
  input  logic        c_wrEn,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic [3:0]  c_mode,
  output logic [31:0] c_rdata,
  output logic        c_rdataEn,
  output logic        c_clkEn,
  // boot loader side
  input  logic        l_req,
  input  logic [31:0] l_addr,
  input  logic [31:0] l_wdata,
  output logic        l_gnt,
  // RAM side
  output logic        ram_en,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_mode,
  input  logic [31:0] ram_rdata,
  // UART side
  output logic        uart_valid,
  output logic        uart_we,
  output logic [3:0]  uart_addr,
  output logic [31:0] uart_wdata,
  input  logic        uart_ready,
  input  logic [31:0] uart_rdata
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_UART_WAIT = 2'd1;
  localparam logic [1:0] S_UART_DONE = 2'd2;

  localparam int CW = (TO_CYC < 1) ? 1 : $clog2(TO_CYC + 1);
  localparam logic [CW:0] TO_LIM = (CW + 1)'(TO_CYC);

  localparam logic [3:0]  LDR_MODE   = 4'b0010;  // word access
  localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

  logic [1:0]    state;
  logic [CW-1:0] to_cnt;
  logic [CW:0]   to_cnt_inc;
  logic          u_we_q;
  logic [3:0]    u_addr_q;
  logic [31:0]   u_wdata_q;
  logic          rd_pend_q;   // RAM read issued last cycle, data arrives now
  logic [31:0]   rdata_q;
  logic          rdata_en_q;

  logic core_req;
  logic is_uart;
  logic idle;
  logic ldr_go;
  logic ram_core;
  logic uart_go;
  logic rd_issue;
  logic uart_timeout;

  assign core_req = c_rdEn | c_wrEn;
  assign is_uart  = (c_addr & UART_MASK) == UART_BASE;
  assign idle     = (state == S_IDLE) && !rst;
  assign ldr_go   = idle && l_req;
  assign ram_core = idle && !l_req && core_req && !is_uart;
  assign uart_go  = idle && !l_req && core_req && is_uart;
  // A simultaneous read+write is a plain store: no read response.
  assign rd_issue = ram_core && c_rdEn && !c_wrEn;

  assign to_cnt_inc   = {1'b0, to_cnt} + 1'b1;
  assign uart_timeout = (state == S_UART_WAIT) && !uart_ready && (to_cnt_inc == TO_LIM);

  // RAM port: loader wins over the core.
  always_comb begin
    l_gnt     = ldr_go;
    ram_en    = ldr_go | ram_core;
    ram_we    = ldr_go | (ram_core & c_wrEn);
    ram_addr  = ldr_go ? l_addr  : c_addr;
    ram_wdata = ldr_go ? l_wdata : c_wdata;
    ram_mode  = ldr_go ? LDR_MODE : c_mode;
  end

  always_comb begin
    c_clkEn = 1'b0;
    if (!rst) begin
      case (state)
        S_IDLE:      c_clkEn = !ldr_go && !uart_go;
        S_UART_WAIT: c_clkEn = 1'b0;
        S_UART_DONE: c_clkEn = 1'b1;
        default:     c_clkEn = 1'b0;
      endcase
    end
  end

  assign uart_valid = (state == S_UART_WAIT);
  assign uart_we    = u_we_q;
  assign uart_addr  = u_addr_q;
  assign uart_wdata = u_wdata_q;
  assign c_rdata    = rdata_q;
  assign c_rdataEn  = rdata_en_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      to_cnt     <= '0;
      u_we_q     <= 1'b0;
      u_addr_q   <= '0;
      u_wdata_q  <= '0;
      rd_pend_q  <= 1'b0;
      rdata_q    <= '0;
      rdata_en_q <= 1'b0;
    end else begin
      rd_pend_q  <= rd_issue;
      rdata_en_q <= 1'b0;
      if (rd_pend_q) begin
        rdata_q    <= ram_rdata;
        rdata_en_q <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (uart_go) begin
            u_we_q    <= c_wrEn;
            u_addr_q  <= c_addr[3:0];
            u_wdata_q <= c_wdata;
            to_cnt    <= '0;
            state     <= S_UART_WAIT;
          end
        end
        S_UART_WAIT: begin
          if (uart_ready) begin
            if (!u_we_q) begin
              rdata_q    <= uart_rdata;
              rdata_en_q <= 1'b1;   // high during UART_DONE
            end
            state <= S_UART_DONE;
          end else if (uart_timeout) begin
            if (!u_we_q) begin
              rdata_q    <= ABORT_DATA;
              rdata_en_q <= 1'b1;
            end
            state <= S_UART_DONE;
          end else begin
            to_cnt <= to_cnt_inc[CW-1:0];
          end
        end
        // The core still presents the finished instruction here; drop it.
        S_UART_DONE: state <= S_IDLE;
        default:     state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/data_bus_ctrl.md
DATA_BUS_CTRL -- requirements
Module: data_bus_ctrl

Interface
REQ-001 SHALL have parameter UART_BASE, default 32'h1000_0000: base address of the UART window.
REQ-002 SHALL have parameter UART_MASK, default 32'hF000_0000: address bits compared against UART_BASE.
REQ-003 SHALL have parameter TO_CYC, default 255: maximum cycles to wait for uart_ready.
REQ-004 SHALL have port clk  in  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1: reset, synchronous, active-high.
REQ-006 SHALL have port c_rdEn  in  1: core load request.
REQ-007 SHALL have port c_wrEn  in  1: core store request.
REQ-008 SHALL have port c_addr  in  32: core byte address.
REQ-009 SHALL have port c_wdata  in  32: core store data.
REQ-010 SHALL have port c_mode  in  4: core access mode {byte, half, word, unsigned}.
REQ-011 SHALL have port c_rdata  out  32: load data returned to core.
REQ-012 SHALL have port c_rdataEn  out  1: one-cycle pulse, c_rdata valid.
REQ-013 SHALL have port c_clkEn  out  1: core clock enable; 0 freezes core.
REQ-014 SHALL have port l_req  in  1: boot-loader word write request.
REQ-015 SHALL have port l_addr  in  32: loader byte address.
REQ-016 SHALL have port l_wdata  in  32: loader write data.
REQ-017 SHALL have port l_gnt  out  1: loader write accepted this cycle.
REQ-018 SHALL have port ram_en  out  1: RAM access strobe.
REQ-019 SHALL have port ram_we  out  1: RAM write (1) / read (0).
REQ-020 SHALL have port ram_addr  out  32: RAM address.
REQ-021 SHALL have port ram_wdata  out  32: RAM write data.
REQ-022 SHALL have port ram_mode  out  4: RAM access mode, same encoding as c_mode.
REQ-023 SHALL have port ram_rdata  in  32: RAM read data, valid the cycle after a ram_en read.
REQ-024 SHALL have port uart_valid  out  1: UART request valid; held until uart_ready.
REQ-025 SHALL have port uart_we  out  1: UART write (1) / read (0).
REQ-026 SHALL have port uart_addr  out  4: UART register offset, c_addr[3:0].
REQ-027 SHALL have port uart_wdata  out  32: UART write data.
REQ-028 SHALL have port uart_ready  in  1: UART accepts request; uart_rdata valid in the same cycle.
REQ-029 SHALL have port uart_rdata  in  32: UART read data.

Function
REQ-030 SHALL decode a core access as UART when (c_addr & UART_MASK) == UART_BASE, else RAM.
REQ-031 SHALL implement FSM states IDLE, UART_WAIT, UART_DONE.
REQ-032 IDLE with l_req=1: SHALL drive ram_en=1, ram_we=1, ram_addr=l_addr, ram_wdata=l_wdata, ram_mode=4'b0010, l_gnt=1, c_clkEn=0 combinationally; loader has priority over core; core request ignored.
REQ-033 IDLE, no l_req, core RAM access: SHALL pass c_addr, c_wdata and c_mode through combinationally, ram_en=1, ram_we=c_wrEn, c_clkEn=1 (zero stall).
REQ-034 A RAM read issued in cycle N SHALL register ram_rdata into c_rdata at the end of N+1 and pulse c_rdataEn in N+2.
REQ-035 c_rdata SHALL hold its last value until the next completion.
REQ-036 c_rdEn=c_wrEn=1 SHALL be treated as a write with no read response.
REQ-037 IDLE, no l_req, core UART access: SHALL drive c_clkEn=0 in that cycle, latch we/addr/wdata, clear the timeout counter, and go to UART_WAIT.
REQ-038 UART_WAIT: SHALL drive uart_valid=1 from latched values and c_clkEn=0; on uart_ready=1, SHALL capture uart_rdata for reads and go to UART_DONE.
REQ-039 UART_WAIT: the counter SHALL increment each cycle without uart_ready; on reaching TO_CYC it SHALL abort to UART_DONE with captured read data 32'hDEAD_BEEF.
REQ-040 UART_DONE: SHALL drive c_clkEn=1, pulse c_rdataEn if the access was a read, drive uart_valid=0, ignore core and loader requests (the still-presented instruction), and go to IDLE.
REQ-041 l_req asserted outside IDLE SHALL wait; l_gnt=0 until IDLE.
REQ-042 uart_valid and ram_en SHALL never be 1 in the same cycle.

Reset
REQ-043 rst=1 SHALL, on the next edge, force IDLE, counter=0, c_rdata=0, c_rdataEn=0, uart_valid=0; no completion pulse SHALL be generated for an access aborted mid-UART.
REQ-044 During rst=1, ram_en=0, l_gnt=0 and c_clkEn=0 SHALL hold combinationally.

Verification
REQ-045 RAM load c_addr=0x100, ram_rdata=0xCAFE0001 -> c_clkEn stays 1; c_rdataEn pulses 2 cycles later with c_rdata=0xCAFE0001.
REQ-046 UART store to 0x1000_0004, data=0x41, uart_ready after 3 cycles -> c_clkEn=0 for 4 cycles, uart_addr=4, uart_we=1, then UART_DONE with c_clkEn=1 and no c_rdataEn.
REQ-047 UART read with uart_ready never asserted, TO_CYC=255 -> abort after 255 cycles, c_rdata=0xDEADBEEF with c_rdataEn pulse.
REQ-048 l_req and core RAM load in the same IDLE cycle -> l_gnt=1, ram_we=1, c_clkEn=0; core load serviced the next cycle.
REQ-049 rst asserted during UART_WAIT -> uart_valid=0 after the next edge, state IDLE, no c_rdataEn pulse.
